// File: rtl/chunked_reduce_condense.sv
// Sequential AND/OR/XOR/NOR condenser: folds an N-bit vector CHUNK bits per cycle
// behind valid/ready handshakes, reporting the result, ones-count and chunks consumed.
module chunked_reduce_condense #(
  parameter int N          = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [N-1:0]                         in_vec,
  input  logic [1:0]                           in_mode,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_result,
  output logic [$clog2(N+1)-1:0]               out_count,
  output logic [$clog2((N/CHUNK)+1)-1:0]       out_chunks,
  output logic                                 out_early
);

  localparam int NUM_CHUNKS = N / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam int KW = $clog2(NUM_CHUNKS + 1);
  localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_AND = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [1:0]    mode_q, mode_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_result_q, out_result_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic [KW-1:0] out_chunks_q, out_chunks_d;
  logic          out_early_q, out_early_d;

  function automatic logic [CW-1:0] popcount(input logic [CHUNK-1:0] x);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) c = c + CW'(x[i]);
    return c;
  endfunction

  logic [CHUNK-1:0] chunk_arr [NUM_CHUNKS];
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
    assign chunk_arr[gi] = vec_q[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] cur_chunk;
  logic             red_and, red_or, red_xor;
  logic             acc_fold, last_chunk, early_hit;
  logic [CW-1:0]    count_sum;

  assign cur_chunk  = chunk_arr[idx_q];
  assign red_and    = &cur_chunk;
  assign red_or     = |cur_chunk;
  assign red_xor    = ^cur_chunk;
  assign count_sum  = count_q + popcount(cur_chunk);
  assign last_chunk = (idx_q == IW'(NUM_CHUNKS - 1));

  // NOR accumulates as OR; the inversion happens only when the result is loaded.
  always_comb begin
    acc_fold = acc_q;
    case (mode_q)
      MODE_AND: acc_fold = acc_q & red_and;
      MODE_XOR: acc_fold = acc_q ^ red_xor;
      default:  acc_fold = acc_q | red_or;
    endcase
  end

  assign early_hit = EARLY_EXIT &&
                     (((mode_q == MODE_AND) && !red_and) ||
                      (((mode_q == MODE_OR) || (mode_q == MODE_NOR)) && red_or));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    mode_d       = mode_q;
    acc_d        = acc_q;
    count_d      = count_q;
    idx_d        = idx_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_count_d  = out_count_q;
    out_chunks_d = out_chunks_q;
    out_early_d  = out_early_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d      = in_vec;
          mode_d     = in_mode;
          idx_d      = '0;
          count_d    = '0;
          acc_d      = (in_mode == MODE_AND);
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = acc_fold;
        count_d = count_sum;
        idx_d   = idx_q + IW'(1);
        if (last_chunk || early_hit) begin
          state_d      = ST_DONE;
          out_valid_d  = 1'b1;
          out_result_d = (mode_q == MODE_NOR) ? ~acc_fold : acc_fold;
          out_count_d  = count_sum;
          out_chunks_d = KW'(idx_q) + KW'(1);
          out_early_d  = !last_chunk;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      mode_q       <= MODE_AND;
      acc_q        <= 1'b0;
      count_q      <= '0;
      idx_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= 1'b0;
      out_count_q  <= '0;
      out_chunks_q <= '0;
      out_early_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_count_q  <= out_count_d;
      out_chunks_q <= out_chunks_d;
      out_early_q  <= out_early_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_count  = out_count_q;
  assign out_chunks = out_chunks_q;
  assign out_early  = out_early_q;

endmodule

// File: tb/tb_chunked_reduce_condense.sv
// Directed bench: two instances (early exit on/off) share stimulus; table of vectors
// plus hand-written backpressure and mid-run reset sequences.
module tb_chunked_reduce_condense;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_vec = '0;
  logic [1:0]  in_mode = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_e, out_valid_e, out_result_e, out_early_e;
  logic [5:0]  out_count_e;
  logic [2:0]  out_chunks_e;
  logic        in_ready_n, out_valid_n, out_result_n, out_early_n;
  logic [5:0]  out_count_n;
  logic [2:0]  out_chunks_n;

  always #5 clk = ~clk;

  chunked_reduce_condense #(.N(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_vec(in_vec), .in_mode(in_mode), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_result(out_result_e), .out_count(out_count_e), .out_chunks(out_chunks_e),
    .out_early(out_early_e)
  );

  chunked_reduce_condense #(.N(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_vec(in_vec), .in_mode(in_mode), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_result(out_result_n), .out_count(out_count_n), .out_chunks(out_chunks_n),
    .out_early(out_early_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] vec;
    int r, c, k, e, lat;   // early-exit instance
    int rn, cn;            // no-early-exit instance (always 4 chunks, latency 4)
  } vec_t;

  vec_t tbl [11];

  int got_lat, got_r, got_c, got_k, got_e;
  int ne_lat, ne_r, ne_c, ne_k, ne_e;

  // Accept one vector on both instances, then capture each one's result and latency.
  task automatic run_vec(input logic [1:0] m, input logic [31:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(in_ready_e && in_ready_n) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_mode  = m;
    in_vec   = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = ~v;
    in_mode  = ~m;
    got_lat = -1; ne_lat = -1;
    got_r = -1; got_c = -1; got_k = -1; got_e = -1;
    ne_r = -1; ne_c = -1; ne_k = -1; ne_e = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (out_valid_e && got_lat < 0) begin
        got_lat = cyc; got_r = int'(out_result_e); got_c = int'(out_count_e);
        got_k = int'(out_chunks_e); got_e = int'(out_early_e);
      end
      if (out_valid_n && ne_lat < 0) begin
        ne_lat = cyc; ne_r = int'(out_result_n); ne_c = int'(out_count_n);
        ne_k = int'(out_chunks_n); ne_e = int'(out_early_n);
      end
      if (got_lat >= 0 && ne_lat >= 0 && !out_ready) break;
      if (got_lat >= 0 && ne_lat >= 0 && cyc >= 5) break;
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 32'hFFFF_FFFF, 1, 32, 4, 0, 4, 1, 32};
    tbl[1]  = '{2'b00, 32'hFFFF_00FF, 0,  8, 2, 1, 2, 0, 24};
    tbl[2]  = '{2'b10, 32'h0000_0007, 1,  3, 4, 0, 4, 1,  3};
    tbl[3]  = '{2'b11, 32'h0000_0000, 1,  0, 4, 0, 4, 1,  0};
    tbl[4]  = '{2'b01, 32'h8000_0000, 1,  1, 4, 0, 4, 1,  1};
    tbl[5]  = '{2'b01, 32'h0000_0100, 1,  1, 2, 1, 2, 1,  1};
    tbl[6]  = '{2'b00, 32'h00FF_FFFF, 0, 24, 4, 0, 4, 0, 24};
    tbl[7]  = '{2'b11, 32'h0000_00F0, 0,  4, 1, 1, 1, 0,  4};
    tbl[8]  = '{2'b10, 32'hFFFF_FFFF, 0, 32, 4, 0, 4, 0, 32};
    tbl[9]  = '{2'b00, 32'h0F0F_0F0E, 0,  3, 1, 1, 1, 0, 15};
    tbl[10] = '{2'b01, 32'h0000_0000, 0,  0, 4, 0, 4, 0,  0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset in_ready", int'(in_ready_e), 1);
    chk("reset out_valid", int'(out_valid_e), 0);
    chk("reset out_result", int'(out_result_e), 0);
    chk("reset out_count", int'(out_count_e), 0);
    chk("reset out_chunks", int'(out_chunks_e), 0);
    chk("reset out_early", int'(out_early_e), 0);

    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i].mode, tbl[i].vec);
      $display("vec %0d mode=%0d in=%08h: result=%0d count=%0d chunks=%0d early=%0d lat=%0d | ne result=%0d count=%0d",
               i, tbl[i].mode, tbl[i].vec, got_r, got_c, got_k, got_e, got_lat, ne_r, ne_c);
      chk($sformatf("v%0d latency", i), got_lat, tbl[i].lat);
      chk($sformatf("v%0d result", i), got_r, tbl[i].r);
      chk($sformatf("v%0d count", i), got_c, tbl[i].c);
      chk($sformatf("v%0d chunks", i), got_k, tbl[i].k);
      chk($sformatf("v%0d early", i), got_e, tbl[i].e);
      chk($sformatf("v%0d ne latency", i), ne_lat, 4);
      chk($sformatf("v%0d ne result", i), ne_r, tbl[i].rn);
      chk($sformatf("v%0d ne count", i), ne_c, tbl[i].cn);
      chk($sformatf("v%0d ne chunks", i), ne_k, 4);
      chk($sformatf("v%0d ne early", i), ne_e, 0);
    end

    // Backpressure: hold result for 5 cycles while pulsing in_valid.
    out_ready = 1'b0;
    run_vec(2'b00, 32'hFFFF_FFFF);
    $display("backpressure: result=%0d count=%0d chunks=%0d lat=%0d", got_r, got_c, got_k, got_lat);
    chk("bp latency", got_lat, 4);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      in_vec   = 32'h0000_0000;
      @(negedge clk);
      chk($sformatf("bp c%0d out_valid", c), int'(out_valid_e), 1);
      chk($sformatf("bp c%0d in_ready", c), int'(in_ready_e), 0);
      chk($sformatf("bp c%0d result", c), int'(out_result_e), 1);
      chk($sformatf("bp c%0d count", c), int'(out_count_e), 32);
      chk($sformatf("bp c%0d chunks", c), int'(out_chunks_e), 4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    $display("bp release: out_valid=%0d in_ready=%0d", out_valid_e, in_ready_e);
    chk("bp release out_valid", int'(out_valid_e), 0);
    chk("bp release in_ready", int'(in_ready_e), 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp no stray accept", int'(in_ready_e), 1);
    end

    // Reset for one edge while chunk 2 is being folded.
    @(negedge clk);
    in_mode = 2'b00; in_vec = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-run reset: out_valid=%0d in_ready=%0d result=%0d count=%0d chunks=%0d early=%0d",
             out_valid_e, in_ready_e, out_result_e, out_count_e, out_chunks_e, out_early_e);
    chk("rst out_valid", int'(out_valid_e), 0);
    chk("rst in_ready", int'(in_ready_e), 1);
    chk("rst out_result", int'(out_result_e), 0);
    chk("rst out_count", int'(out_count_e), 0);
    chk("rst out_chunks", int'(out_chunks_e), 0);
    chk("rst out_early", int'(out_early_e), 0);
    chk("rst ne out_valid", int'(out_valid_n), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst stale c%0d", c), int'(out_valid_e), 0);
    end
    run_vec(2'b00, 32'hFFFF_FFFF);
    $display("post-reset vector: result=%0d count=%0d chunks=%0d lat=%0d", got_r, got_c, got_k, got_lat);
    chk("post-rst latency", got_lat, 4);
    chk("post-rst result", got_r, 1);
    chk("post-rst count", got_c, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
